// File: rtl/serial_pattern_detector.sv
// -----------------------------------------------------------------------------
// serial_pattern_detector
//
// Detects an N-bit programmable pattern in a validity-qualified serial bit
// stream. The pattern and a per-bit don't-care mask are shifted in MSB first
// while prgm_en is held high. Once N bits are captured the detector arms and
// the pattern stays locked until prgm_en is dropped and raised again.
//
// Parameters:
//   N      pattern length in bits (2..32)
//   CNT_W  width of the saturating match counter
//
// Ports:
//   clk        system clock, rising edge
//   clr        asynchronous active-low reset
//   prgm_en    program enable; high while pattern/mask bits are presented
//   prgm       serial pattern bit, MSB first
//   msk        serial mask bit, MSB first (1 = don't-care)
//   sig        serial data bit under test
//   sig_vld    qualifies sig; a bit is consumed only when high
//   overlap    1 = overlapping matches, 0 = non-overlapping
//   out        registered one-cycle match pulse
//   armed      high while a complete pattern is loaded and detection is active
//   match_cnt  saturating count of matches since last reset or program
// -----------------------------------------------------------------------------
module serial_pattern_detector #(
  parameter int N     = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             prgm_en,
  input  logic             prgm,
  input  logic             msk,
  input  logic             sig,
  input  logic             sig_vld,
  input  logic             overlap,
  output logic             out,
  output logic             armed,
  output logic [CNT_W-1:0] match_cnt
);

  // Counter wide enough to hold the value N itself.
  localparam int              LW      = $clog2(N + 1);
  localparam logic [LW-1:0]   N_CNT   = LW'(N);
  localparam logic [LW-1:0]   LAST    = LW'(N - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ARMED = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [N-1:0]     pat_reg, pat_next;
  logic [N-1:0]     mask_reg, mask_next;
  // Only the newest N-1 history bits need storing: the compare window is
  // always those bits plus the bit arriving on the current edge.
  logic [N-2:0]     hist_reg, hist_next;
  logic [LW-1:0]    load_cnt_reg, load_cnt_next;
  logic [LW-1:0]    fill_cnt_reg, fill_cnt_next;
  logic [CNT_W-1:0] match_cnt_reg, match_cnt_next;
  logic             out_reg, out_next;
  logic             prgm_en_d_reg;

  logic             prgm_rise;
  logic             start_load;
  logic [N-1:0]     window;
  logic [N-1:0]     bit_ok;
  logic             pattern_hit;
  logic [LW-1:0]    fill_inc;
  logic [CNT_W-1:0] match_cnt_inc;

  // A reload from ARMED needs a fresh prgm_en assertion, so the tail of the
  // assertion that completed the load cannot overwrite the locked pattern.
  assign prgm_rise  = prgm_en & ~prgm_en_d_reg;
  assign start_load = ((state_reg == IDLE)  & prgm_en) |
                      ((state_reg == ARMED) & prgm_rise);

  // Window under test on this edge: stored history plus the incoming bit.
  assign window = {hist_reg, sig};

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_cmp
      assign bit_ok[gi] = mask_reg[gi] | (window[gi] == pat_reg[gi]);
    end
  endgenerate

  assign pattern_hit = &bit_ok;

  assign fill_inc      = (fill_cnt_reg == N_CNT) ? N_CNT : fill_cnt_reg + LW'(1);
  assign match_cnt_inc = (match_cnt_reg == CNT_MAX) ? CNT_MAX
                                                    : match_cnt_reg + CNT_W'(1);

  // ---------------------------------------------------------------------------
  // Next-state / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    pat_next       = pat_reg;
    mask_next      = mask_reg;
    hist_next      = hist_reg;
    load_cnt_next  = load_cnt_reg;
    fill_cnt_next  = fill_cnt_reg;
    match_cnt_next = match_cnt_reg;
    out_next       = 1'b0;

    if (start_load) begin
      // Entering LOAD captures the first bit and discards all detection state.
      // This path also takes priority over a completing data bit in ARMED.
      state_next     = LOAD;
      pat_next       = {pat_reg[N-2:0], prgm};
      mask_next      = {mask_reg[N-2:0], msk};
      load_cnt_next  = LW'(1);
      hist_next      = '0;
      fill_cnt_next  = '0;
      match_cnt_next = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next = IDLE;
        end

        LOAD: begin
          if (prgm_en) begin
            pat_next      = {pat_reg[N-2:0], prgm};
            mask_next     = {mask_reg[N-2:0], msk};
            load_cnt_next = load_cnt_reg + LW'(1);
            if (load_cnt_reg == LAST) begin
              state_next = ARMED;
            end
          end else begin
            // Aborted load: partial pattern is abandoned.
            state_next    = IDLE;
            load_cnt_next = '0;
          end
        end

        ARMED: begin
          if (sig_vld) begin
            hist_next     = window[N-2:0];
            fill_cnt_next = fill_inc;
            if ((fill_inc == N_CNT) && pattern_hit) begin
              out_next       = 1'b1;
              match_cnt_next = match_cnt_inc;
              // Non-overlapping mode needs N fresh bits before the next match.
              if (!overlap) begin
                fill_cnt_next = '0;
              end
            end
          end
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_reg     <= IDLE;
      pat_reg       <= '0;
      mask_reg      <= '0;
      hist_reg      <= '0;
      load_cnt_reg  <= '0;
      fill_cnt_reg  <= '0;
      match_cnt_reg <= '0;
      out_reg       <= 1'b0;
      prgm_en_d_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pat_reg       <= pat_next;
      mask_reg      <= mask_next;
      hist_reg      <= hist_next;
      load_cnt_reg  <= load_cnt_next;
      fill_cnt_reg  <= fill_cnt_next;
      match_cnt_reg <= match_cnt_next;
      out_reg       <= out_next;
      prgm_en_d_reg <= prgm_en;
    end
  end

  assign out       = out_reg;
  assign armed     = (state_reg == ARMED);
  assign match_cnt = match_cnt_reg;

endmodule

// File: tb/tb_serial_pattern_detector.sv
// -----------------------------------------------------------------------------
// tb_serial_pattern_detector
//
// Drives two detector instances (N=4, CNT_W=8 and N=4, CNT_W=2) from the same
// inputs and compares them every cycle against a behavioural model built from
// queues of loaded and consumed bits.
// -----------------------------------------------------------------------------
module tb_serial_pattern_detector;
  localparam int N = 4;

  logic clk = 1'b0;
  logic clr = 1'b1;
  logic prgm_en = 1'b0, prgm = 1'b0, msk = 1'b0;
  logic sig = 1'b0, sig_vld = 1'b0, overlap = 1'b1;
  logic out_a, armed_a, out_b, armed_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serial_pattern_detector #(.N(N), .CNT_W(8)) dut_a (
    .clk(clk), .clr(clr), .prgm_en(prgm_en), .prgm(prgm), .msk(msk),
    .sig(sig), .sig_vld(sig_vld), .overlap(overlap),
    .out(out_a), .armed(armed_a), .match_cnt(cnt_a)
  );

  serial_pattern_detector #(.N(N), .CNT_W(2)) dut_b (
    .clk(clk), .clr(clr), .prgm_en(prgm_en), .prgm(prgm), .msk(msk),
    .sig(sig), .sig_vld(sig_vld), .overlap(overlap),
    .out(out_b), .armed(armed_b), .match_cnt(cnt_b)
  );

  // ---------------------------------------------------------------- model ---
  bit         m_armed, m_session, m_prev_en, m_out;
  bit         m_lp[$], m_lm[$];   // bits of the load in progress
  bit         m_bits[$];          // valid data bits eligible for the window
  logic [N-1:0] m_pat, m_msk;
  int         m_count;

  function automatic void model_reset();
    m_armed = 0; m_session = 0; m_prev_en = 0; m_out = 0;
    m_lp.delete(); m_lm.delete(); m_bits.delete();
    m_pat = '0; m_msk = '0; m_count = 0;
  endfunction

  function automatic bit window_ok();
    int base = m_bits.size() - N;
    for (int i = 0; i < N; i++)
      if (!m_msk[N-1-i] && (m_bits[base+i] != m_pat[N-1-i])) return 0;
    return 1;
  endfunction

  // Applies the effect of one clock edge given the currently driven inputs.
  function automatic void model_edge();
    bit rise = prgm_en && !m_prev_en;
    m_out = 0;
    if (m_session) begin
      if (prgm_en) begin
        m_lp.push_back(prgm); m_lm.push_back(msk);
        if (m_lp.size() == N) begin
          for (int i = 0; i < N; i++) begin
            m_pat[N-1-i] = m_lp[i];
            m_msk[N-1-i] = m_lm[i];
          end
          m_session = 0; m_armed = 1;
        end
      end else begin
        m_session = 0;
      end
    end else if (prgm_en && (!m_armed || rise)) begin
      m_session = 1; m_armed = 0;
      m_lp.delete(); m_lm.delete();
      m_lp.push_back(prgm); m_lm.push_back(msk);
      m_bits.delete(); m_count = 0;
    end else if (m_armed && sig_vld) begin
      m_bits.push_back(sig);
      if (m_bits.size() > N) void'(m_bits.pop_front());
      if (m_bits.size() == N && window_ok()) begin
        m_out = 1; m_count++;
        if (!overlap) m_bits.delete();
      end
    end
    m_prev_en = prgm_en;
  endfunction

  function automatic logic [13:0] exp_vec();
    logic [7:0] ca = (m_count > 255) ? 8'd255 : 8'(m_count);
    logic [1:0] cb = (m_count > 3) ? 2'd3 : 2'(m_count);
    return {m_out, m_armed, ca, m_out, m_armed, cb};
  endfunction

  function automatic logic [13:0] obs();
    return {out_a, armed_a, cnt_a, out_b, armed_b, cnt_b};
  endfunction

  // Drive one cycle of inputs, advance the model, sample #1 after the edge.
  task automatic step(input logic pe, p, mk, s, sv, ov);
    prgm_en = pe; prgm = p; msk = mk; sig = s; sig_vld = sv; overlap = ov;
    model_edge();
    @(posedge clk); #1;
  endtask

  // Stimulus only: one idle cycle (so prgm_en rises) then N pattern bits.
  task automatic load(input logic [N-1:0] p, input logic [N-1:0] mk);
    step(0, 0, 0, 0, 0, overlap);
    for (int i = N - 1; i >= 0; i--) step(1, p[i], mk[i], 0, 0, overlap);
    step(0, 0, 0, 0, 0, overlap);
  endtask

  // ---------------------------------------------------------------- tests ---
  task automatic test_reset();
    #2 clr = 1'b0;
    model_reset();
    #1;
    if (obs() !== 14'd0) begin
      miscompares++;
      $display("FAIL reset_async: got %h expected %h", obs(), 14'd0);
    end
    vectors++;
    @(posedge clk); #1;
    if (obs() !== exp_vec()) begin
      miscompares++;
      $display("FAIL reset_hold: got %h expected %h", obs(), exp_vec());
    end
    vectors++;
    clr = 1'b1;
  endtask

  task automatic test_basic();
    logic [15:0] s = 16'b1010000101000000;
    logic [N-1:0] p = 4'b1010;
    int pulses = 0;
    overlap = 1;
    for (int i = N - 1; i >= 0; i--) begin
      step(1, p[i], 0, 0, 0, 1);
      if (obs() !== exp_vec() || armed_a !== (i == 0)) begin
        miscompares++;
        $display("FAIL basic_load bit %0d: got %h expected %h", N - i, obs(), exp_vec());
      end
      vectors++;
    end
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 0, s[15-i], 1, 1);
      if (out_a) pulses++;
      if (obs() !== exp_vec() || out_a !== (i == 3 || i == 10)) begin
        miscompares++;
        $display("FAIL basic_stream bit %0d: got %h expected %h", i + 1, obs(), exp_vec());
      end
      vectors++;
    end
    if (pulses != 2 || cnt_a !== 8'd2) begin
      miscompares++;
      $display("FAIL basic_total: got pulses=%0d cnt=%0d expected 2/2", pulses, cnt_a);
    end
    vectors++;
  endtask

  task automatic test_overlap();
    logic [7:0] s = 8'b10101010;
    for (int ov = 1; ov >= 0; ov--) begin
      int pulses = 0;
      overlap = 1'(ov);
      load(4'b1010, 4'b0000);
      for (int i = 0; i < 8; i++) begin
        step(0, 0, 0, s[7-i], 1, 1'(ov));
        if (out_a) pulses++;
        if (obs() !== exp_vec()) begin
          miscompares++;
          $display("FAIL overlap%0d bit %0d: got %h expected %h", ov, i + 1, obs(), exp_vec());
        end
        vectors++;
      end
      if (pulses != (ov ? 3 : 2) || cnt_a !== 8'(ov ? 3 : 2)) begin
        miscompares++;
        $display("FAIL overlap%0d_total: got pulses=%0d cnt=%0d expected %0d", ov, pulses, cnt_a, ov ? 3 : 2);
      end
      vectors++;
    end
  endtask

  task automatic test_mask();
    logic [3:0] streams [3] = '{4'b1011, 4'b1010, 4'b0010};
    int exp_p [3] = '{1, 1, 0};
    overlap = 1;
    for (int r = 0; r < 3; r++) begin
      logic [3:0] s = streams[r];
      int pulses = 0;
      load(4'b1010, 4'b0001);
      for (int i = 0; i < 4; i++) begin
        step(0, 0, 0, s[3-i], 1, 1);
        if (out_a) pulses++;
        if (obs() !== exp_vec()) begin
          miscompares++;
          $display("FAIL mask run %0d bit %0d: got %h expected %h", r, i + 1, obs(), exp_vec());
        end
        vectors++;
      end
      if (pulses != exp_p[r]) begin
        miscompares++;
        $display("FAIL mask_total run %0d: got %0d pulses expected %0d", r, pulses, exp_p[r]);
      end
      vectors++;
    end
  endtask

  task automatic test_long_load();
    logic [5:0] p = 6'b101011;
    logic [7:0] s = 8'b11111010;
    int pulses = 0;
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      step(1, p[5-i], 0, 0, 0, 1);
      if (obs() !== exp_vec() || armed_a !== (i >= 3)) begin
        miscompares++;
        $display("FAIL long_load cycle %0d: got %h expected %h", i + 1, obs(), exp_vec());
      end
      vectors++;
    end
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, s[7-i], 1, 1);
      if (out_a) pulses++;
      if (obs() !== exp_vec() || out_a !== (i == 7)) begin
        miscompares++;
        $display("FAIL long_load_stream bit %0d: got %h expected %h", i + 1, obs(), exp_vec());
      end
      vectors++;
    end
    if (pulses != 1) begin
      miscompares++;
      $display("FAIL long_load_total: got %0d pulses expected 1", pulses);
    end
    vectors++;
  endtask

  task automatic test_short_load();
    logic [7:0] s = 8'b10101010;
    step(0, 0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, s[7-i], 1, 1);
      if (obs() !== exp_vec() || out_a !== 1'b0 || armed_a !== 1'b0) begin
        miscompares++;
        $display("FAIL short_load bit %0d: got %h expected %h", i + 1, obs(), exp_vec());
      end
      vectors++;
    end
    load(4'b1010, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, s[7-i], 1, 1);
      if (obs() !== exp_vec() || out_a !== (i == 3)) begin
        miscompares++;
        $display("FAIL short_reload bit %0d: got %h expected %h", i + 1, obs(), exp_vec());
      end
      vectors++;
    end
  endtask

  task automatic test_prog_collision();
    logic [3:0] s = 4'b1010;
    load(4'b1010, 4'b0000);
    for (int i = 0; i < 3; i++) step(0, 0, 0, s[3-i], 1, 1);
    step(1, 1, 0, s[0], 1, 1);   // completing bit coincides with new load
    if (obs() !== exp_vec() || out_a !== 1'b0 || armed_a !== 1'b0 || cnt_a !== 8'd0) begin
      miscompares++;
      $display("FAIL prog_collision: got %h expected %h", obs(), exp_vec());
    end
    vectors++;
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 1);
    if (obs() !== exp_vec() || armed_a !== 1'b1) begin
      miscompares++;
      $display("FAIL prog_collision_reload: got %h expected %h", obs(), exp_vec());
    end
    vectors++;
  endtask

  task automatic test_saturate();
    int pulses = 0;
    load(4'b1111, 4'b0000);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 1, 1, 1);
      if (out_b) pulses++;
      if (obs() !== exp_vec()) begin
        miscompares++;
        $display("FAIL saturate bit %0d: got %h expected %h", i + 1, obs(), exp_vec());
      end
      vectors++;
    end
    if (pulses != 5 || cnt_b !== 2'd3 || cnt_a !== 8'd5) begin
      miscompares++;
      $display("FAIL saturate_total: got pulses=%0d cnt_b=%0d cnt_a=%0d expected 5/3/5", pulses, cnt_b, cnt_a);
    end
    vectors++;
    // Asynchronous reset between edges, while out/armed/count are all set.
    #3 clr = 1'b0;
    model_reset();
    #1;
    if (obs() !== 14'd0) begin
      miscompares++;
      $display("FAIL saturate_async_reset: got %h expected %h", obs(), 14'd0);
    end
    vectors++;
    prgm_en = 0; sig_vld = 1; sig = 1;
    @(posedge clk); #1;
    if (obs() !== 14'd0) begin
      miscompares++;
      $display("FAIL saturate_reset_hold: got %h expected %h", obs(), 14'd0);
    end
    vectors++;
    clr = 1'b1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 29) == 0) begin
        int len = $urandom_range(1, 6);
        step(0, 0, 0, 0, 0, overlap);
        for (int k = 0; k < len; k++)
          step(1, 1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom), overlap);
      end else begin
        logic ov = ($urandom_range(0, 19) == 0) ? ~overlap : overlap;
        step(0, 0, 0, 1'($urandom), 1'($urandom_range(0, 3) != 0), ov);
      end
      if (obs() !== exp_vec()) begin
        miscompares++;
        $display("FAIL random cycle %0d: got %h expected %h", n, obs(), exp_vec());
      end
      vectors++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_overlap();
    test_mask();
    test_long_load();
    test_short_load();
    test_prog_collision();
    test_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
